// File: rtl/tim_sel_mux_pipe_if.sv
// Stream interface for tim_sel_mux_pipe: upstream beat, downstream beat and count sideband.
interface tim_sel_mux_pipe_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
    parameter int unsigned CNT_W  = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [SEL_W-1:0]          in_sel;
    logic [NUM_IN*WIDTH-1:0]   in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          out_data;
    logic                      out_oor;
    logic [CNT_W-1:0]          oor_count;
    logic                      clear_count;

    // Producer/consumer side (drives beats in, accepts beats out)
    modport master (
        output in_valid, in_sel, in_data, out_ready, clear_count,
        input  in_ready, out_valid, out_data, out_oor, oor_count
    );

    // Selector side
    modport slave (
        input  in_valid, in_sel, in_data, out_ready, clear_count,
        output in_ready, out_valid, out_data, out_oor, oor_count
    );
endinterface

// File: rtl/tim_sel_mux_pipe.sv
// Registered N-channel selector with valid/ready stream, 2-entry skid and out-of-range counter.
module tim_sel_mux_pipe #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      NUM_IN      = 4,
    parameter int unsigned      SEL_W       = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
    parameter int unsigned      CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    tim_sel_mux_pipe_if.slave  bus
);

    typedef struct packed {
        logic             oor;
        logic [WIDTH-1:0] data;
    } beat_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam beat_t            RESET_BEAT = '{oor: 1'b0, data: DEFAULT_VAL};
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state_q, state_d;
    beat_t            out_q, out_d;
    beat_t            skid_q, skid_d;
    logic             out_valid_q;
    logic             in_ready_q;
    logic [CNT_W-1:0] cnt_q;
    beat_t            sel_beat_c;
    logic             accept_c;
    logic             emit_c;

    assign accept_c = bus.in_valid & in_ready_q;
    assign emit_c   = out_valid_q & bus.out_ready;

    // Channel select; anything not matching a channel index falls to the default value
    always_comb begin
        sel_beat_c.data = DEFAULT_VAL;
        sel_beat_c.oor  = 1'b1;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (bus.in_sel == SEL_W'(k)) begin
                sel_beat_c.data = bus.in_data[k*WIDTH +: WIDTH];
                sel_beat_c.oor  = 1'b0;
            end
        end
    end

    // Occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy next-state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: if (accept_c) state_d = ST_ONE;
            ST_ONE: begin
                if (accept_c && !emit_c)      state_d = ST_TWO;
                else if (!accept_c && emit_c) state_d = ST_EMPTY;
            end
            ST_TWO:   if (emit_c) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Next values of the output and skid registers
    always_comb begin
        out_d  = out_q;
        skid_d = skid_q;
        unique case (state_q)
            ST_EMPTY: if (accept_c) out_d = sel_beat_c;
            ST_ONE: begin
                if (accept_c && emit_c)  out_d  = sel_beat_c;
                else if (accept_c)       skid_d = sel_beat_c;
            end
            ST_TWO:   if (emit_c) out_d = skid_q;
            default: begin
                out_d  = RESET_BEAT;
                skid_d = RESET_BEAT;
            end
        endcase
    end

    // Beat storage plus registered handshake flags derived from next occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= RESET_BEAT;
            skid_q      <= RESET_BEAT;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= (state_d != ST_EMPTY);
            in_ready_q  <= (state_d != ST_TWO);
        end
    end

    // Saturating out-of-range counter, counted on accept; clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (bus.clear_count) begin
            cnt_q <= '0;
        end else if (accept_c && sel_beat_c.oor && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_q.data;
    assign bus.out_oor   = out_q.oor;
    assign bus.oor_count = cnt_q;

endmodule

// File: tb/tb_tim_sel_mux_pipe.sv
// Randomised and directed check of tim_sel_mux_pipe against a queue-based stream model.
module tb_tim_sel_mux_pipe;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned NUM_IN = 4;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned CNT_W  = 2;
    localparam logic [7:0]  DEFV   = 8'hA5;
    localparam int unsigned CMAX   = 3;

    typedef struct {
        logic [7:0] data;
        logic       oor;
    } exp_beat_t;

    bit clk = 1'b0;
    bit rst_n = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    exp_beat_t   q[$];
    int unsigned exp_cnt = 0;
    bit          last_acc;

    tim_sel_mux_pipe_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

    tim_sel_mux_pipe #(
        .WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .DEFAULT_VAL(DEFV), .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Single comparison point
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
        check_eq("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check_eq("out_data", 32'(bus.out_data), 32'(q[0].data));
            check_eq("out_oor", 32'(bus.out_oor), 32'(q[0].oor));
        end
        check_eq("oor_count", 32'(bus.oor_count), exp_cnt);
    endtask

    task automatic drive(input bit v, input int unsigned sel, input logic [31:0] data,
                         input bit ordy, input bit clr);
        bus.in_valid    = v;
        bus.in_sel      = SEL_W'(sel);
        bus.in_data     = data;
        bus.out_ready   = ordy;
        bus.clear_count = clr;
    endtask

    // One clock: predict handshakes from the model, advance it, then compare
    task automatic tick();
        bit        acc, emt;
        exp_beat_t b;
        int unsigned s;
        s   = int'(bus.in_sel);
        acc = bus.in_valid && (q.size() < 2);
        emt = bus.out_ready && (q.size() != 0);
        if (s < NUM_IN) begin
            b.data = 8'((bus.in_data >> (8 * s)) & 32'hFF);
            b.oor  = 1'b0;
        end else begin
            b.data = DEFV;
            b.oor  = 1'b1;
        end
        @(posedge clk);
        if (emt) void'(q.pop_front());
        if (acc) q.push_back(b);
        if (bus.clear_count) exp_cnt = 0;
        else if (acc && b.oor && exp_cnt < CMAX) exp_cnt++;
        last_acc = acc;
        #1;
        check_outputs();
    endtask

    initial begin
        drive(1'b0, 0, 32'h0, 1'b0, 1'b0);
        #12;
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_out_data", 32'(bus.out_data), 32'(DEFV));
        check_eq("rst_out_oor", 32'(bus.out_oor), 32'd0);
        check_eq("rst_count", 32'(bus.oor_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // In-range selects, free-flowing output
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i, 32'h44332211, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 0, 32'h0, 1'b1, 1'b0);
        tick();

        // Out-of-range select returns the default value
        drive(1'b1, 5, 32'h44332211, 1'b1, 1'b0);
        tick();
        check_eq("oor_first_data", 32'(bus.out_data), 32'(DEFV));
        check_eq("oor_first_cnt", 32'(bus.oor_count), 32'd1);
        drive(1'b0, 0, 32'h0, 1'b1, 1'b0);
        tick();

        // Backpressure: two beats stored, third waits for space
        for (int i = 0; i < 3; i++) begin
            int guard;
            guard = 0;
            drive(1'b1, i, 32'hD4C3B2A1 + 32'(i), 1'b0, 1'b0);
            if (i == 2) begin
                tick();
                tick();
                check_eq("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
                bus.out_ready = 1'b1;
            end
            do begin
                tick();
                guard++;
            end while (!last_acc && guard < 20);
            check_eq("bp_accept_timeout", 32'(guard < 20), 32'd1);
        end
        drive(1'b0, 0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick();

        // Counter saturation and clear priority
        drive(1'b0, 0, 32'h0, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 6, 32'h0, 1'b1, 1'b0);
            tick();
        end
        check_eq("cnt_saturated", 32'(bus.oor_count), 32'd3);
        drive(1'b1, 7, 32'h0, 1'b1, 1'b1);
        tick();
        check_eq("cnt_clear_prio", 32'(bus.oor_count), 32'd0);

        // Fill both slots, then reset asynchronously
        drive(1'b1, 1, 32'h0000_5A00, 1'b0, 1'b0);
        tick();
        tick();
        check_eq("two_in_ready", 32'(bus.in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("async_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("async_out_data", 32'(bus.out_data), 32'(DEFV));
        q.delete();
        exp_cnt = 0;
        drive(1'b0, 0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Random traffic against the stream model
        for (int i = 0; i < 10000; i++) begin
            drive(($urandom % 4) != 0, $urandom_range(0, 7), $urandom,
                  ($urandom % 3) != 0, ($urandom % 64) == 0);
            tick();
        end
        drive(1'b0, 0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        check_eq("drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tim_sel_mux_pipe.md
Name: tim_sel_mux_pipe

Overview:
Parametrised N-channel, WIDTH-bit registered selector with a valid/ready stream interface and a 2-entry skid buffer. Every select value maps to a defined output: out-of-range selects return DEFAULT_VAL and are flagged and counted. The output path is latch-free and fully registered. It sits between datapath stages that need a registered, backpressure-tolerant channel select.

Parameters:
WIDTH, 8, data width per channel (>=1)
NUM_IN, 4, number of input channels (>=2)
SEL_W, $clog2(NUM_IN) (min 1), select width; may be widened beyond minimum so out-of-range codes exist
DEFAULT_VAL, '0, WIDTH-bit value returned for out-of-range select
CNT_W, 8, width of out-of-range event counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous reset, active low
in_valid  input  1  upstream beat valid
in_ready  output  1  upstream may transfer; registered, equals "skid slot empty"
in_sel  input  SEL_W  channel select for this beat
in_data  input  NUM_IN*WIDTH  packed channels, channel k at [k*WIDTH +: WIDTH]
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts
out_data  output  WIDTH  selected data
out_oor  output  1  beat was produced from an out-of-range select
oor_count  output  CNT_W  saturating count of accepted out-of-range beats
clear_count  input  1  synchronous clear of oor_count

Behaviour:
- Reset (async assert, sync deassert by upstream): out_valid=0, out_data=DEFAULT_VAL, out_oor=0, in_ready=1, oor_count=0, skid empty.
- Accept = in_valid & in_ready; emit = out_valid & out_ready.
- Select: in_sel < NUM_IN -> channel in_sel, oor=0; otherwise DEFAULT_VAL, oor=1. Selection is a complete assignment with default; no latch on any path.
- Latency: accepted beat appears on out_* the next cycle when the output register is empty or emitting.
- States (skid occupancy): EMPTY (out reg free), ONE (out reg valid, skid empty), TWO (out reg and skid valid).
  - EMPTY: accept -> ONE.
  - ONE: accept & !emit -> TWO (beat parked in skid); accept & emit -> ONE (new beat to out reg); !accept & emit -> EMPTY.
  - TWO: in_ready=0; emit -> ONE (skid moves to out reg, same cycle).
- in_ready is a flop: 0 only in TWO. No combinational path from out_ready to in_ready.
- Order is strictly preserved; data, oor and valid travel together; out_* stable while out_valid & !out_ready.
- oor_count: +1 per accepted oor beat (counted at accept, not emit); saturates at 2^CNT_W-1; clear_count has priority over increment in the same cycle (result 0).
- Reset mid-stream discards both stored beats; no beat is emitted after reset release until a new accept.
- in_sel/in_data ignored when !accept.

Test Plan:
- NUM_IN=4, SEL_W=3, out_ready=1: accept sel=0..3 with data 0x11,0x22,0x33,0x44 -> out_data 0x11,0x22,0x33,0x44 one cycle later, out_oor=0, in_ready stays 1.
- sel=5 with DEFAULT_VAL=0xA5 -> out_data=0xA5, out_oor=1, oor_count 0->1.
- out_ready=0, three back-to-back beats -> first two held (out reg + skid), in_ready=0 on cycle 3, third beat waits; release out_ready -> all three emitted in order, no drop or duplicate.
- CNT_W=2: five oor accepts -> oor_count 1,2,3,3,3; clear_count coincident with an oor accept -> 0.
- Assert rst_n=0 while in TWO -> out_valid=0 and in_ready=1 immediately (async); after release, no stale beat emitted.
- Random valid/ready/sel (10k cycles) vs scoreboard -> exact order/data match, out_* stable under stall.
